// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: per-register pending-write scoreboard, RAW/WAW stall, jump bubble and branch flush.
// Optional macro STALL_CNT_EN adds the perf_stall_cnt stall-cycle counter (constant 0 otherwise).
module id_hazard_ctrl #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int CNTW      = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [5:0]      id_opcode,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_regwrite,
  input  logic            id_regdst,
  input  logic            ex_ready,
  input  logic            ex_branch_taken,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  output logic            id_issue,
  output logic            id_stall,
  output logic            id_kill,
  output logic            jump_take,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_underflow,
  output logic [31:0]     perf_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_JBUB  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [5:0]      OP_J       = 6'b000010;
  localparam logic [5:0]      OP_JAL     = 6'b000011;
  localparam logic [AW-1:0]   REG_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0]   REG_LINK   = AW'(31);
  localparam logic [CNTW-1:0] CNT_ZERO   = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};
  localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_flush_cnt;
  logic [2:0]      w_flush_nxt;
  logic [CNTW-1:0] r_cnt [NREG];
  logic [CNTW-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_underflow;

  logic [AW-1:0]   w_dest;
  logic            w_dest_wr;
  logic            w_rs_busy;
  logic            w_rt_busy;
  logic            w_hazard;
  logic            w_is_jump;
  logic            w_issue;
  logic            w_stall;
  logic            w_kill;
  logic            w_jump;
  logic [NREG-1:0] w_inc_vec;
  logic [NREG-1:0] w_dec_vec;
  logic            w_uf_evt;

  always_comb begin
    if (id_opcode == OP_JAL) begin
      w_dest = REG_LINK;
    end else if (id_regdst) begin
      w_dest = id_rd;
    end else begin
      w_dest = id_rt;
    end
  end

  assign w_dest_wr = id_regwrite & (w_dest != REG_ZERO);
  assign w_rs_busy = id_uses_rs & (id_rs != REG_ZERO) & (r_cnt[id_rs] != CNT_ZERO);
  assign w_rt_busy = id_uses_rt & (id_rt != REG_ZERO) & (r_cnt[id_rt] != CNT_ZERO);
  // A saturated destination counter cannot take another in-flight write.
  assign w_hazard  = w_rs_busy | w_rt_busy | (w_dest_wr & (r_cnt[w_dest] == CNT_MAX));
  assign w_is_jump = (id_opcode == OP_J) | (id_opcode == OP_JAL);

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    w_issue     = 1'b0;
    w_stall     = 1'b0;
    w_kill      = 1'b0;
    w_jump      = 1'b0;
    if (rst) begin
      w_state_nxt = ST_RUN;
      w_flush_nxt = 3'd0;
    end else if (ex_branch_taken) begin
      // Branch outranks any pending jump or bubble; flush length includes this cycle.
      w_kill = 1'b1;
      if (FLUSH_CYC == 1) begin
        w_state_nxt = ST_RUN;
        w_flush_nxt = 3'd0;
      end else begin
        w_state_nxt = ST_FLUSH;
        w_flush_nxt = FLUSH_LOAD;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          w_stall = id_valid & (w_hazard | ~ex_ready);
          w_issue = id_valid & ~w_stall;
          if (w_issue & w_is_jump) begin
            w_jump      = 1'b1;
            w_state_nxt = ST_JBUB;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_JBUB: begin
          w_kill      = 1'b1;
          w_state_nxt = ST_RUN;
        end
        ST_FLUSH: begin
          w_kill = 1'b1;
          if (r_flush_cnt <= 3'd1) begin
            w_flush_nxt = 3'd0;
            w_state_nxt = ST_RUN;
          end else begin
            w_flush_nxt = r_flush_cnt - 3'd1;
            w_state_nxt = ST_FLUSH;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_inc_vec = {NREG{1'b0}};
    w_dec_vec = {NREG{1'b0}};
    if (w_issue & w_dest_wr) begin
      w_inc_vec[w_dest] = 1'b1;
    end else begin
      w_inc_vec = {NREG{1'b0}};
    end
    if (wb_valid & (wb_addr != REG_ZERO)) begin
      w_dec_vec[wb_addr] = 1'b1;
    end else begin
      w_dec_vec = {NREG{1'b0}};
    end
  end

  // Issue and writeback on the same register cancel, including at zero.
  always_comb begin
    w_uf_evt = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (i == 0) begin
        w_cnt_nxt[i] = CNT_ZERO;
      end else if (w_inc_vec[i] & ~w_dec_vec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end else if (~w_inc_vec[i] & w_dec_vec[i]) begin
        if (r_cnt[i] != CNT_ZERO) begin
          w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
        end else begin
          w_uf_evt = 1'b1;
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= {NREG{1'b0}};
      r_underflow <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      r_underflow <= r_underflow | w_uf_evt;
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i]  <= w_cnt_nxt[i];
        r_busy[i] <= (w_cnt_nxt[i] != CNT_ZERO);
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cnt <= 32'd0;
    end else if (w_stall) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end else begin
      r_perf_cnt <= r_perf_cnt;
    end
  end

  assign perf_stall_cnt = r_perf_cnt;
`else
  assign perf_stall_cnt = 32'd0;
`endif

  assign id_issue     = w_issue;
  assign id_stall     = w_stall;
  assign id_kill      = w_kill;
  assign jump_take    = w_jump;
  assign busy_vec     = r_busy;
  assign wb_underflow = r_underflow;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios plus randomized traffic against a pending-write count model.
module tb_id_hazard_ctrl;
  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_regdst;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd, wb_addr;
  logic        ex_ready, ex_branch_taken, wb_valid;
  logic        id_issue, id_stall, id_kill, jump_take, wb_underflow;
  logic [31:0] busy_vec, perf_stall_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  int          pend [32];
  int          kill_left;
  bit          uf;
  logic [31:0] scnt;
  logic        e_issue, e_stall, e_kill, e_jt;
  logic [31:0] e_busy, e_perf;
  int          e_dest;
  bit          e_wr;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.NREG(32), .AW(5), .CNTW(2), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite), .id_regdst(id_regdst),
    .ex_ready(ex_ready), .ex_branch_taken(ex_branch_taken), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .id_issue(id_issue), .id_stall(id_stall), .id_kill(id_kill),
    .jump_take(jump_take), .busy_vec(busy_vec), .wb_underflow(wb_underflow),
    .perf_stall_cnt(perf_stall_cnt)
  );

  task automatic set_in(input bit v, input logic [5:0] op, input int rs, input int rt,
                        input int rd, input bit urs, input bit urt, input bit rw, input bit rdst);
    id_valid = v; id_opcode = op; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_uses_rs = urs; id_uses_rt = urt; id_regwrite = rw; id_regdst = rdst;
  endtask

  task automatic set_side(input bit rdy, input bit br, input bit wbv, input int wba, input bit r);
    ex_ready = rdy; ex_branch_taken = br; wb_valid = wbv; wb_addr = 5'(wba); rst = r;
  endtask

  task automatic model_comb();
    bit haz;
    e_dest = (id_opcode == 6'd3) ? 31 : (id_regdst ? int'(id_rd) : int'(id_rt));
    e_wr   = id_regwrite && (e_dest != 0);
    haz = (id_uses_rs && id_rs != 5'd0 && pend[id_rs] > 0) ||
          (id_uses_rt && id_rt != 5'd0 && pend[id_rt] > 0) ||
          (e_wr && pend[e_dest] >= 3);
    e_issue = 1'b0; e_stall = 1'b0; e_kill = 1'b0; e_jt = 1'b0;
    if (rst) begin
      e_kill = 1'b0;
    end else if (ex_branch_taken || kill_left > 0) begin
      e_kill = 1'b1;
    end else begin
      e_stall = id_valid && (haz || !ex_ready);
      e_issue = id_valid && !e_stall;
      e_jt    = e_issue && (id_opcode == 6'd2 || id_opcode == 6'd3);
    end
  endtask

  task automatic clock_edge();
    bit inc;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
      kill_left = 0; uf = 0; scnt = 32'd0;
    end else begin
      inc = e_issue && e_wr;
      if (inc) pend[e_dest]++;
      if (wb_valid && wb_addr != 5'd0) begin
        if (inc && e_dest == int'(wb_addr)) pend[e_dest]--;
        else if (pend[wb_addr] == 0) uf = 1;
        else pend[wb_addr]--;
      end
      if (ex_branch_taken) kill_left = FLUSH_CYC - 1;
      else if (kill_left > 0) kill_left--;
      else if (e_jt) kill_left = 1;
      if (e_stall) scnt = scnt + 32'd1;
    end
    e_busy = 32'd0;
    for (int i = 1; i < 32; i++) e_busy[i] = (pend[i] > 0);
`ifdef STALL_CNT_EN
    e_perf = scnt;
`else
    e_perf = 32'd0;
`endif
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      set_in(1, 6'd3, 5, 6, 7, 1, 1, 1, 1); set_side(1, c == 0, 1, 9, 1);
      #1; model_comb();
      n_cmp++; if ({id_issue, id_stall, id_kill, jump_take} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ctl c%0d: got %b expected 0000", c, {id_issue, id_stall, id_kill, jump_take});
      end
      clock_edge();
      n_cmp++; if ({busy_vec, wb_underflow, perf_stall_cnt} !== {32'd0, 1'b0, 32'd0}) begin
        n_fail++; $display("FAIL reset_state c%0d: got %h/%b/%0d expected 0/0/0", c, busy_vec, wb_underflow, perf_stall_cnt);
      end
    end
  endtask

  task automatic test_raw();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      case (c)
        0:       begin set_in(1, 6'd0, 1, 2, 5, 1, 1, 1, 1); set_side(1, 0, 0, 0, 0); end
        4:       begin set_in(1, 6'd0, 5, 0, 6, 1, 0, 1, 1); set_side(1, 0, 1, 5, 0); end
        6:       begin set_in(0, 6'd0, 0, 0, 0, 0, 0, 0, 0); set_side(1, 0, 1, 6, 0); end
        default: begin set_in(1, 6'd0, 5, 0, 6, 1, 0, 1, 1); set_side(1, 0, 0, 0, 0); end
      endcase
      #1; model_comb();
      n_cmp++; if ({id_issue, id_stall, id_kill, jump_take} !== {e_issue, e_stall, e_kill, e_jt}) begin
        n_fail++; $display("FAIL raw_ctl c%0d: got %b expected %b", c, {id_issue, id_stall, id_kill, jump_take}, {e_issue, e_stall, e_kill, e_jt});
      end
      if (c == 4) begin
        n_cmp++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_on_wb: got %b expected 1", id_stall); end
      end
      if (c == 5) begin
        n_cmp++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL raw_issue_after_wb: got %b expected 1", id_issue); end
      end
      clock_edge();
      n_cmp++; if ({busy_vec, wb_underflow, perf_stall_cnt} !== {e_busy, uf, e_perf}) begin
        n_fail++; $display("FAIL raw_state c%0d: got %h/%b/%0d expected %h/%b/%0d", c, busy_vec, wb_underflow, perf_stall_cnt, e_busy, uf, e_perf);
      end
      if (c == 0) begin
        n_cmp++; if (busy_vec[5] !== 1'b1) begin n_fail++; $display("FAIL raw_busy5: got %b expected 1", busy_vec[5]); end
      end
    end
  endtask

  task automatic test_r0();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1, 6'd0, 1, 2, 0, 1, 1, 1, 1);
      else        set_in(1, 6'd0, 0, 0, 8, 1, 1, 0, 1);
      set_side(1, 0, 0, 0, 0);
      #1; model_comb();
      n_cmp++; if ({id_issue, id_stall} !== 2'b10) begin
        n_fail++; $display("FAIL r0_ctl c%0d: got issue/stall %b expected 10", c, {id_issue, id_stall});
      end
      clock_edge();
      n_cmp++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL r0_busy c%0d: got %h expected 0", c, busy_vec); end
    end
  endtask

  task automatic test_jal();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      case (c)
        0:       begin set_in(1, 6'd3, 0, 0, 0, 0, 0, 1, 0); set_side(1, 0, 0, 0, 0); end
        3:       begin set_in(0, 6'd0, 0, 0, 0, 0, 0, 0, 0); set_side(1, 0, 1, 31, 0); end
        4:       begin set_in(0, 6'd0, 0, 0, 0, 0, 0, 0, 0); set_side(1, 0, 1, 3, 0); end
        default: begin set_in(1, 6'd0, 1, 2, 3, 1, 1, 1, 1); set_side(1, 0, 0, 0, 0); end
      endcase
      #1; model_comb();
      n_cmp++; if ({id_issue, id_stall, id_kill, jump_take} !== {e_issue, e_stall, e_kill, e_jt}) begin
        n_fail++; $display("FAIL jal_ctl c%0d: got %b expected %b", c, {id_issue, id_stall, id_kill, jump_take}, {e_issue, e_stall, e_kill, e_jt});
      end
      if (c == 0) begin
        n_cmp++; if (jump_take !== 1'b1) begin n_fail++; $display("FAIL jal_jump_take: got %b expected 1", jump_take); end
      end
      if (c == 1) begin
        n_cmp++; if ({id_kill, id_issue} !== 2'b10) begin n_fail++; $display("FAIL jal_bubble: got kill/issue %b expected 10", {id_kill, id_issue}); end
      end
      clock_edge();
      n_cmp++; if ({busy_vec, wb_underflow, perf_stall_cnt} !== {e_busy, uf, e_perf}) begin
        n_fail++; $display("FAIL jal_state c%0d: got %h/%b/%0d expected %h/%b/%0d", c, busy_vec, wb_underflow, perf_stall_cnt, e_busy, uf, e_perf);
      end
      if (c == 0) begin
        n_cmp++; if (busy_vec[31] !== 1'b1) begin n_fail++; $display("FAIL jal_busy31: got %b expected 1", busy_vec[31]); end
      end
    end
  endtask

  task automatic test_branch();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0 || c == 3) set_in(1, 6'd2, 0, 0, 0, 0, 0, 0, 0);
      else                  set_in(1, 6'd0, 1, 2, 4, 1, 1, 0, 1);
      set_side(1, (c == 0 || c == 4), 0, 0, 0);
      #1; model_comb();
      n_cmp++; if ({id_issue, id_stall, id_kill, jump_take} !== {e_issue, e_stall, e_kill, e_jt}) begin
        n_fail++; $display("FAIL br_ctl c%0d: got %b expected %b", c, {id_issue, id_stall, id_kill, jump_take}, {e_issue, e_stall, e_kill, e_jt});
      end
      if (c == 0) begin
        n_cmp++; if ({jump_take, id_kill, id_issue} !== 3'b010) begin n_fail++; $display("FAIL br_over_jump: got jt/kill/issue %b expected 010", {jump_take, id_kill, id_issue}); end
      end
      if (c == 1) begin
        n_cmp++; if (id_kill !== 1'b1) begin n_fail++; $display("FAIL br_flush_kill: got %b expected 1", id_kill); end
      end
      if (c == 2) begin
        n_cmp++; if ({id_kill, id_issue} !== 2'b01) begin n_fail++; $display("FAIL br_back_to_run: got kill/issue %b expected 01", {id_kill, id_issue}); end
      end
      clock_edge();
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 6) set_in(1, 6'h23, 1, 7, 0, 1, 0, 1, 0);
      else       set_in(0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
      set_side(1, 0, (c == 2 || c >= 5), 7, 0);
      #1; model_comb();
      n_cmp++; if ({id_issue, id_stall, id_kill, jump_take} !== {e_issue, e_stall, e_kill, e_jt}) begin
        n_fail++; $display("FAIL sat_ctl c%0d: got %b expected %b", c, {id_issue, id_stall, id_kill, jump_take}, {e_issue, e_stall, e_kill, e_jt});
      end
      if (c == 3) begin
        n_cmp++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL sat_third_ok: got %b expected 1", id_issue); end
      end
      if (c == 4) begin
        n_cmp++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL sat_full_stall: got %b expected 1", id_stall); end
      end
      clock_edge();
      n_cmp++; if ({busy_vec, wb_underflow, perf_stall_cnt} !== {e_busy, uf, e_perf}) begin
        n_fail++; $display("FAIL sat_state c%0d: got %h/%b/%0d expected %h/%b/%0d", c, busy_vec, wb_underflow, perf_stall_cnt, e_busy, uf, e_perf);
      end
    end
  endtask

  task automatic test_underflow();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_in(0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
      set_side(1, 0, (c == 0), 9, (c == 3));
      #1; model_comb();
      clock_edge();
      n_cmp++; if ({busy_vec, wb_underflow} !== {e_busy, uf}) begin
        n_fail++; $display("FAIL uf_state c%0d: got %h/%b expected %h/%b", c, busy_vec, wb_underflow, e_busy, uf);
      end
      if (c == 2) begin
        n_cmp++; if (wb_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b expected 1", wb_underflow); end
      end
      if (c == 3) begin
        n_cmp++; if (wb_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_rst_clear: got %b expected 0", wb_underflow); end
      end
    end
  endtask

  task automatic test_perf();
    logic [31:0] want;
`ifdef STALL_CNT_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 1)       set_in(1, 6'd0, 1, 2, 5, 1, 1, 1, 1);
      else if (c == 14) set_in(0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
      else              set_in(1, 6'd0, 5, 0, 6, 1, 0, 1, 1);
      set_side(1, 0, (c == 12 || c == 14), (c == 14) ? 6 : 5, (c == 0));
      #1; model_comb();
      n_cmp++; if ({id_issue, id_stall, id_kill, jump_take} !== {e_issue, e_stall, e_kill, e_jt}) begin
        n_fail++; $display("FAIL perf_ctl c%0d: got %b expected %b", c, {id_issue, id_stall, id_kill, jump_take}, {e_issue, e_stall, e_kill, e_jt});
      end
      clock_edge();
      if (c == 11) begin
        n_cmp++; if (perf_stall_cnt !== want) begin n_fail++; $display("FAIL perf_ten: got %0d expected %0d", perf_stall_cnt, want); end
      end
      n_cmp++; if ({busy_vec, wb_underflow, perf_stall_cnt} !== {e_busy, uf, e_perf}) begin
        n_fail++; $display("FAIL perf_state c%0d: got %h/%b/%0d expected %h/%b/%0d", c, busy_vec, wb_underflow, perf_stall_cnt, e_busy, uf, e_perf);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    int r [4];
    ops = '{6'h00, 6'h02, 6'h03, 6'h23, 6'h2b, 6'h04};
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        r[k] = int'($urandom_range(0, 8));
        if (r[k] == 8) r[k] = 31;
      end
      set_in($urandom_range(0, 3) != 0, ops[$urandom_range(0, 5)], r[0], r[1], r[2],
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1));
      set_side($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1), r[3],
               $urandom_range(0, 99) == 0);
      #1; model_comb();
      n_cmp++; if ({id_issue, id_stall, id_kill, jump_take} !== {e_issue, e_stall, e_kill, e_jt}) begin
        n_fail++; $display("FAIL rnd_ctl c%0d: got %b expected %b", c, {id_issue, id_stall, id_kill, jump_take}, {e_issue, e_stall, e_kill, e_jt});
      end
      clock_edge();
      n_cmp++; if ({busy_vec, wb_underflow, perf_stall_cnt} !== {e_busy, uf, e_perf}) begin
        n_fail++; $display("FAIL rnd_state c%0d: got %h/%b/%0d expected %h/%b/%0d", c, busy_vec, wb_underflow, perf_stall_cnt, e_busy, uf, e_perf);
      end
    end
  endtask

  initial begin
    set_in(0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
    set_side(1, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) pend[i] = 0;
    kill_left = 0; uf = 0; scnt = 32'd0;
    test_reset();
    test_raw();
    test_r0();
    test_jal();
    test_branch();
    test_saturate();
    test_underflow();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Scoreboard-based issue controller for the instruction-decode stage. It tracks in-flight register writes and stalls decode on RAW/WAW hazards. It sequences the decode slot through jump bubbles and branch flushes. It sits beside the decode stage, consumes its decoded fields (opcode, rs/rt/rd) plus EX/WB status, and drives stall/kill/issue to fetch, decode and EX.

Parameters:
NREG, 32, number of architectural registers (register 0 hardwired, never busy)
AW, 5, register address width
CNTW, 2, width of per-register pending-write counter (max 2^CNTW-1 in flight)
FLUSH_CYC, 2, decode-kill cycles after a taken branch (1..7)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a valid instruction
id_opcode  in  6  instr[31:26]
id_rs  in  AW  instr[25:21]
id_rt  in  AW  instr[20:16]
id_rd  in  AW  instr[15:11]
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_regwrite  in  1  instruction writes a register (from Control)
id_regdst  in  1  1: dest = rd, 0: dest = rt
ex_ready  in  1  EX can accept an instruction this cycle
ex_branch_taken  in  1  branch resolved taken in EX (single-cycle pulse)
wb_valid  in  1  writeback retiring a register write
wb_addr  in  AW  register written back
id_issue  out  1  instruction moves ID->EX this cycle
id_stall  out  1  hold IF and ID registers
id_kill  out  1  squash instruction in ID (insert bubble)
jump_take  out  1  redirect fetch to jumpDest (one-cycle pulse)
busy_vec  out  NREG  bit i = register i has pending write(s)
wb_underflow  out  1  sticky error: writeback to register with zero pending
perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset: all counters 0, state RUN, every output 0, wb_underflow cleared.
- Dest: opcode 000011 (jal) -> 31; else id_regdst ? rd : rt. No scoreboard effect when id_regwrite=0 or dest=0.
- hazard = (id_uses_rs & cnt[rs]!=0 & rs!=0) | (id_uses_rt & cnt[rt]!=0 & rt!=0) | (dest counter saturated at 2^CNTW-1).
- States: RUN, JBUB, FLUSH.
- RUN: id_stall = id_valid & (hazard | !ex_ready); id_issue = id_valid & !id_stall. id_kill=0.
- id_issue of opcode 000010/000011: jump_take=1 that same cycle (combinational), next state JBUB.
- JBUB (one cycle): id_kill=1, id_issue=0, id_stall=0. Next state RUN.
- ex_branch_taken in any state: id_kill=1 and id_issue=0 that cycle, jump_take suppressed. Load flush counter = FLUSH_CYC-1, go to FLUSH; if FLUSH_CYC=1, return to RUN. Branch takes priority over jump and over JBUB.
- FLUSH: id_kill=1, id_issue=0. Decrement each cycle; RUN after reaching 0. ex_branch_taken during FLUSH reloads the counter.
- Counter update per register, same edge: +1 on issue with that dest; -1 on wb_valid to that addr. Both on same register in same cycle: unchanged. Writes to register 0 are ignored.
- wb to a counter at 0 (addr!=0): counter stays 0, wb_underflow set until rst.
- busy_vec is registered: it reflects counters after the edge. Stall decision uses current counters; a same-cycle wb does not unblock until the next cycle. No WB bypass.
- rst mid-flush or mid-stall: returns to RUN and clears all counters the next cycle.

Optional Feature:
STALL_CNT_EN defined: perf_stall_cnt increments each cycle id_stall=1. It wraps at 2^32 and is cleared by rst. Undefined: perf_stall_cnt is constant 0 and no counter logic is generated.

Test Plan:
- Issue add rd=5, then add rs=5 next cycle -> second held (id_stall=1, busy_vec[5]=1) until wb_valid wb_addr=5. Issue the cycle after wb.
- Issue to rd=0, then a reader of r0 -> no stall, busy_vec=0.
- Issue jal (opcode 000011) -> jump_take=1 same cycle, id_kill=1 next cycle, busy_vec[31]=1.
- ex_branch_taken with FLUSH_CYC=2 while a jump issues -> jump_take=0, id_kill high 2 cycles, then RUN.
- Three issues to rt=7 with no wb (CNTW=2) -> third accepted, fourth stalls. Same-cycle issue+wb to r7 leaves counter at 3.
- wb_valid wb_addr=9 with nothing pending -> wb_underflow=1 and stays set. rst clears it. With STALL_CNT_EN, 10 stall cycles -> perf_stall_cnt=10.
